// File: rtl/out_ctrl_sc_if.sv
// rtl/out_ctrl_sc_if.sv - SC input stream and binary output port bundle for out_ctrl_sc
//
// Purpose: groups the SC bit input and the valid/ready sample output of out_ctrl_sc.
// Signals:
//   sc_valid   qualifies sc_bit this cycle
//   sc_bit     one SC bit per lane
//   out_ready  sink accepts out_data
//   out_valid  out_data holds a completed sample vector
//   out_data   lane k at bits [k*N_BITS +: N_BITS]
//   out_ovf    sticky: a completed window was dropped
// Modports: slave = the converter, master = the environment driving it.
interface out_ctrl_sc_if #(
  parameter int N_BITS    = 8,
  parameter int NUM_LANES = 4
);
  logic                        sc_valid;
  logic [NUM_LANES-1:0]        sc_bit;
  logic                        out_ready;
  logic                        out_valid;
  logic [NUM_LANES*N_BITS-1:0] out_data;
  logic                        out_ovf;

  modport master (
    output sc_valid, sc_bit, out_ready,
    input  out_valid, out_data, out_ovf
  );

  modport slave (
    input  sc_valid, sc_bit, out_ready,
    output out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/out_ctrl_sc.sv
// rtl/out_ctrl_sc.sv - SC-to-binary output converter with small output FIFO
//
// Purpose: counts ones in each of NUM_LANES stochastic bitstreams over a window of
//   2**N_BITS valid cycles, saturates each count to N_BITS, and queues the completed
//   sample vector in a FIFO_DEPTH-entry FIFO that drains on a valid/ready port.
// Ports:
//   clock  single clock, posedge
//   reset  synchronous, active-high; clears counters, FIFO and overflow flag
//   bus    out_ctrl_sc_if.slave: sc_valid/sc_bit in, out_ready in,
//          out_valid/out_data/out_ovf out
// Configuration macro: OUT_CTRL_SC_BIPOLAR_EN
//   defined   -> each lane is emitted as two's complement (count - L/2)
//   undefined -> each lane is emitted as the unsigned saturated ones count
module out_ctrl_sc #(
  parameter int N_BITS     = 8,
  parameter int NUM_LANES  = 4,
  parameter int FIFO_DEPTH = 2
) (
  input logic          clock,
  input logic          reset,
  out_ctrl_sc_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = NUM_LANES * N_BITS;
  localparam logic [N_BITS-1:0] WIN_LAST = '1;

  logic [N_BITS-1:0] win_cnt;
  logic [N_BITS:0]   lane_cnt [NUM_LANES];
  logic [N_BITS:0]   lane_sum [NUM_LANES];
  logic [N_BITS-1:0] lane_sat [NUM_LANES];
  logic [DW-1:0]     sample;
  logic [DW-1:0]     mem [FIFO_DEPTH];
  logic [DW-1:0]     last_pop;
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              ovf;
  logic              win_end;
  logic              empty;
  logic              full;
  logic              push;
  logic              pop;

  assign win_end = bus.sc_valid && (win_cnt == WIN_LAST);

  // lane_sum already includes this cycle's bit, so at window end the final bit is
  // part of the pushed sample. Only an all-ones window reaches L, hence the saturation.
  always_comb begin
    sample = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      lane_sum[k] = lane_cnt[k] + {{N_BITS{1'b0}}, (bus.sc_valid & bus.sc_bit[k])};
      lane_sat[k] = lane_sum[k][N_BITS] ? {N_BITS{1'b1}} : lane_sum[k][N_BITS-1:0];
`ifdef OUT_CTRL_SC_BIPOLAR_EN
      // Flipping the MSB of an offset-binary count yields two's complement count-L/2.
      sample[k*N_BITS +: N_BITS] = {~lane_sat[k][N_BITS-1], lane_sat[k][N_BITS-2:0]};
`else
      sample[k*N_BITS +: N_BITS] = lane_sat[k];
`endif
    end
  end

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && bus.out_ready;
  // A simultaneous pop frees the slot, so a push while full is still accepted.
  assign push  = win_end && (!full || pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      win_cnt  <= '0;
      for (int k = 0; k < NUM_LANES; k++) lane_cnt[k] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      last_pop <= '0;
      ovf      <= 1'b0;
    end else begin
      if (bus.sc_valid) win_cnt <= win_cnt + 1'b1;
      for (int k = 0; k < NUM_LANES; k++) begin
        lane_cnt[k] <= win_end ? '0 : lane_sum[k];
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        last_pop <= mem[rd_ptr[AW-1:0]];
      end
      if (win_end && full && !pop) ovf <= 1'b1;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clock) begin
    if (push && !reset) mem[wr_ptr[AW-1:0]] <= sample;
  end

  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? last_pop : mem[rd_ptr[AW-1:0]];
  assign bus.out_ovf   = ovf;
endmodule

// File: tb/tb_out_ctrl_sc.sv
// tb/tb_out_ctrl_sc.sv - scoreboard testbench for out_ctrl_sc
module tb_out_ctrl_sc;
  localparam int NB    = 8;
  localparam int NL    = 4;
  localparam int DEPTH = 2;
  localparam int L     = 256;

`ifdef OUT_CTRL_SC_BIPOLAR_EN
  localparam logic [31:0] T1_EXP = 32'hC0_00_80_7F;
  localparam logic [31:0] T5_EXP = 32'h7F_7F_7F_7F;
`else
  localparam logic [31:0] T1_EXP = 32'h40_80_00_FF;
  localparam logic [31:0] T5_EXP = 32'hFF_FF_FF_FF;
`endif

  logic clock = 1'b0;
  logic reset;

  out_ctrl_sc_if #(.N_BITS(NB), .NUM_LANES(NL)) bus ();

  out_ctrl_sc #(.N_BITS(NB), .NUM_LANES(NL), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int beats = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] encode(input int c0, input int c1, input int c2, input int c3);
    int c[4];
    logic [7:0] v;
    logic [31:0] r;
    c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      v = (c[k] >= L) ? 8'hFF : 8'(c[k]);
`ifdef OUT_CTRL_SC_BIPOLAR_EN
      v = v ^ 8'h80;
`endif
      r[k*8 +: 8] = v;
    end
    return r;
  endfunction

  // Monitor: every accepted beat is matched against the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got %h expected none", bus.out_data);
        end else begin
          check($sformatf("beat%0d", beats), bus.out_data, exp_q.pop_front());
        end
        beats++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // mode: 0 fixed test pattern, 1 lane k ones in first c_k cycles, 2 random, 3 all ones
  // rmode: 0 ready low, 1 ready high, 2 random, 3 high only on the last valid cycle
  task automatic feed(input int mode, input int nvalid, input int c0, input int c1,
                      input int c2, input int c3, input int idle_pct, input int rmode,
                      input bit push_exp, input bit use_hand, input logic [31:0] hand,
                      input bit lat_chk);
    int ones[4];
    logic [3:0] b;
    int i;
    ones[0] = 0; ones[1] = 0; ones[2] = 0; ones[3] = 0;
    i = 0;
    while (i < nvalid) begin
      @(posedge clock); #1;
      if (idle_pct > 0 && $urandom_range(99) < idle_pct) begin
        bus.sc_valid = 1'b0;
        bus.sc_bit   = 4'($urandom);
        bus.out_ready = (rmode == 1) ? 1'b1 : (rmode == 2) ? 1'($urandom_range(1)) : 1'b0;
      end else begin
        case (mode)
          0:       b = {(i % 4 == 0), (i % 2 == 0), 1'b0, 1'b1};
          1:       b = {(i < c3), (i < c2), (i < c1), (i < c0)};
          2:       b = 4'($urandom);
          default: b = 4'hF;
        endcase
        for (int k = 0; k < 4; k++) ones[k] += int'(b[k]);
        bus.sc_valid = 1'b1;
        bus.sc_bit   = b;
        bus.out_ready = (rmode == 1) ? 1'b1 : (rmode == 2) ? 1'($urandom_range(1)) :
                        (rmode == 3) ? (i == nvalid - 1) : 1'b0;
        if (i == nvalid - 1 && push_exp)
          exp_q.push_back(use_hand ? hand : encode(ones[0], ones[1], ones[2], ones[3]));
        i++;
      end
    end
    if (lat_chk) begin
      @(negedge clock);
      check("t2_valid_before_end", 32'(bus.out_valid), 32'd0);
    end
    @(posedge clock); #1;
    bus.sc_valid = 1'b0;
    if (rmode == 3) bus.out_ready = 1'b0;
    if (lat_chk) check("t2_valid_t_plus_1", 32'(bus.out_valid), 32'd1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    @(posedge clock); #1;
    bus.out_ready = 1'b1;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    check({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    check({name, "_valid_after"}, 32'(bus.out_valid), 32'd0);
  endtask

  task automatic do_reset(input string name);
    @(posedge clock); #1;
    reset = 1'b1;
    bus.sc_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    check({name, "_valid"}, 32'(bus.out_valid), 32'd0);
    check({name, "_data"}, bus.out_data, 32'd0);
    check({name, "_ovf"}, 32'(bus.out_ovf), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus.sc_valid = 1'b0;
    bus.sc_bit = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_data", bus.out_data, 32'd0);
    check("rst_ovf", 32'(bus.out_ovf), 32'd0);

    // 1: fixed patterns, ready high
    feed(0, L, 0, 0, 0, 0, 0, 1, 1'b1, 1'b1, T1_EXP, 1'b0);
    drain("t1");

    // 2: same stream with idle gaps, latency check
    feed(0, L, 0, 0, 0, 0, 30, 1, 1'b1, 1'b1, T1_EXP, 1'b1);
    drain("t2");

    // 3: stalled sink, third window dropped
    feed(1, L, 10, 0, 0, 0, 0, 0, 1'b1, 1'b0, '0, 1'b0);
    feed(1, L, 20, 0, 0, 0, 0, 0, 1'b1, 1'b0, '0, 1'b0);
    feed(1, L, 30, 0, 0, 0, 0, 0, 1'b0, 1'b0, '0, 1'b0);
    @(negedge clock);
    check("t3_ovf", 32'(bus.out_ovf), 32'd1);
    check("t3_valid", 32'(bus.out_valid), 32'd1);
    check("t3_head", bus.out_data, encode(10, 0, 0, 0));
    repeat (5) @(negedge clock);
    check("t3_head_stable", bus.out_data, encode(10, 0, 0, 0));
    drain("t3");
    check("t3_hold_last", bus.out_data, encode(20, 0, 0, 0));
    check("t3_ovf_sticky", 32'(bus.out_ovf), 32'd1);
    do_reset("t3_rst");

    // 4: full FIFO, window end coincides with a pop
    feed(1, L, 5, 0, 0, 0, 0, 0, 1'b1, 1'b0, '0, 1'b0);
    feed(1, L, 6, 0, 0, 0, 0, 0, 1'b1, 1'b0, '0, 1'b0);
    feed(1, L, 7, 1, 2, 3, 0, 3, 1'b1, 1'b0, '0, 1'b0);
    @(negedge clock);
    check("t4_ovf", 32'(bus.out_ovf), 32'd0);
    check("t4_pending", 32'(exp_q.size()), 32'd2);
    drain("t4");

    // 5: reset mid-window discards the partial counts
    bus.out_ready = 1'b1;
    feed(3, 100, 0, 0, 0, 0, 0, 1, 1'b0, 1'b0, '0, 1'b0);
    do_reset("t5_rst");
    feed(3, L, 0, 0, 0, 0, 0, 1, 1'b1, 1'b1, T5_EXP, 1'b0);
    drain("t5");

    // 6: random bits, random ready, back-to-back windows
    for (int w = 0; w < 8; w++) begin
      feed(2, L, 0, 0, 0, 0, 10, 2, 1'b1, 1'b0, '0, 1'b0);
    end
    drain("t6");
    check("t6_ovf", 32'(bus.out_ovf), 32'd0);
    check("beat_count", 32'(beats), 32'd16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
